arb8_grant_ctrl: RTL

//  Shares one downstream resource between 8 requesters. The block grants one

---
 rtl/arb8_grant_ctrl_if.sv | 30 +++
 rtl/arb8_grant_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/arb8_grant_ctrl_if.sv
// Request/grant bundle between the requester bank and the 8-way grant
// controller. The slave side is the arbiter; the master side is the bank.
//
// Handshake: a requester raises req[i] and keeps it high for as long as it
// wants the resource. The arbiter answers with a registered one-hot gnt,
// and holds it while req[gnt_idx] stays high, up to the hold limit. The
// requester lowers req[i] to hand the resource back. A grant is never
// handed straight to another requester: at least one idle cycle always
// separates two grants. dbg_state mirrors the FSM state (0 = IDLE,
// 1 = GRANT) for monitors.
interface arb8_grant_ctrl_if;
  logic       en;
  logic       rr_mode;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic       dbg_state;

  modport master (
    output en, rr_mode, req,
    input  gnt, gnt_idx, gnt_valid, timeout, dbg_state
  );

  modport slave (
    input  en, rr_mode, req,
    output gnt, gnt_idx, gnt_valid, timeout, dbg_state
  );
endinterface

// File: rtl/arb8_grant_ctrl.sv
// 8-requester grant controller. It grants one requester at a time, either
// by fixed priority (the highest index wins) or round-robin. The grant is
// held until the owner drops its request or the hold limit runs out, and
// two grants are always separated by an idle cycle. All outputs are
// registered.
module arb8_grant_ctrl #(
  parameter int MAX_HOLD = 16  // 0 disables the hold limit; legal 0..255
) (
  input  logic          clk,
  input  logic          rst_n,
  arb8_grant_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit         HOLD_LIMIT_EN = (MAX_HOLD != 0);
  // Value of hold_cnt in the last allowed cycle of a grant.
  localparam logic [7:0] HOLD_LAST     = 8'(MAX_HOLD - 1);

  state_t     state, state_d;
  logic [7:0] hold_cnt, hold_d;
  logic [2:0] last_idx, last_d;
  logic [2:0] idx_d;
  logic       timeout_d;
  logic [7:0] gnt_d;
  logic       valid_d;

  logic [2:0] fixed_win;
  logic [2:0] rr_win;
  logic [2:0] winner;

  // Fixed priority: the highest set request index wins.
  always_comb begin
    fixed_win = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.req[i]) fixed_win = 3'(i);
    end
  end

  // Round-robin: the first set bit scanning last_idx+1 .. last_idx+8 (mod 8).
  // Walking k downwards makes the nearest candidate the last one written.
  always_comb begin
    rr_win = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      if (bus.req[3'(last_idx + 3'(k))]) rr_win = 3'(last_idx + 3'(k));
    end
  end

  assign winner = bus.rr_mode ? rr_win : fixed_win;

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold_cnt      <= 8'd0;
      last_idx      <= 3'd7;
      bus.gnt       <= 8'd0;
      bus.gnt_idx   <= 3'd0;
      bus.gnt_valid <= 1'b0;
      bus.timeout   <= 1'b0;
    end else begin
      state         <= state_d;
      hold_cnt      <= hold_d;
      last_idx      <= last_d;
      bus.gnt       <= gnt_d;
      bus.gnt_idx   <= idx_d;
      bus.gnt_valid <= valid_d;
      bus.timeout   <= timeout_d;
    end
  end

  // Next-state logic: arbitrate in IDLE; in GRANT release first, then the
  // hold limit, otherwise keep the grant and count.
  always_comb begin
    state_d   = state;
    hold_d    = hold_cnt;
    last_d    = last_idx;
    idx_d     = bus.gnt_idx;
    timeout_d = 1'b0;
    unique case (state)
      IDLE: begin
        idx_d  = 3'd0;
        hold_d = 8'd0;
        if (bus.en && (bus.req != 8'd0)) begin
          state_d = GRANT;
          idx_d   = winner;
          last_d  = winner;
        end
      end
      GRANT: begin
        if (!bus.en || !bus.req[bus.gnt_idx]) begin
          state_d = IDLE;
          idx_d   = 3'd0;
          hold_d  = 8'd0;
        end else if (HOLD_LIMIT_EN && (hold_cnt == HOLD_LAST)) begin
          state_d   = IDLE;
          idx_d     = 3'd0;
          hold_d    = 8'd0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
        hold_d  = 8'd0;
      end
    endcase
  end

  // Output decode of the next grant from the next state and index.
  always_comb begin
    valid_d = (state_d == GRANT);
    gnt_d   = valid_d ? (8'b1 << idx_d) : 8'b0;
  end

  assign bus.dbg_state = state;

endmodule
